cpu_trace_parser: RTL and testbench

- Byte-serial checker and field extractor for CPU trace lines, one ASCII character per cycle.
- Recognises register-write lines `^<time>@<pc>: $<grf> <= <data>#` and memory-write lines `^<time>@<pc>: *<addr> <= <data>#`.
- Reports the line type, latches the decoded fields and flags semantic errors.
- Keeps a saturating count of malformed lines. Sits beside the trace monitor in the test harness.

---
 rtl/cpu_trace_parser.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cpu_trace_parser.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_parser.sv
// cpu_trace_parser: byte-serial checker and field extractor for CPU trace
// lines of the form ^<time>@<pc>: $<grf> <= <data># (register write) or
// ^<time>@<pc>: *<addr> <= <data># (memory write). Decoded fields are latched
// when a line completes; malformed and semantically bad lines are counted.
module cpu_trace_parser #(
  parameter int TIME_DIGITS = 4,
  parameter int GRF_DIGITS  = 4,
  parameter int HEX_DIGITS  = 8,
  parameter int TIME_W      = 16,
  parameter int GRF_W       = 14,
  parameter int ERR_W       = 8,
  localparam int HW         = 4 * HEX_DIGITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  output logic [1:0]        format_type,
  output logic              line_valid,
  output logic              sem_err,
  output logic [TIME_W-1:0] time_val,
  output logic [HW-1:0]     pc_val,
  output logic [GRF_W-1:0]  grf_idx,
  output logic [HW-1:0]     addr_val,
  output logic [HW-1:0]     data_val,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int MAXD_A = (TIME_DIGITS > GRF_DIGITS) ? TIME_DIGITS : GRF_DIGITS;
  localparam int MAXD   = (MAXD_A > HEX_DIGITS) ? MAXD_A : HEX_DIGITS;
  localparam int CW     = $clog2(MAXD + 1) + 1;

  localparam logic [7:0] CH_CARET = 8'h5E;
  localparam logic [7:0] CH_AT    = 8'h40;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_DOLL  = 8'h24;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_LT    = 8'h3C;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_HASH  = 8'h23;

  typedef enum logic [3:0] {
    S_IDLE, S_TIME, S_PC, S_SP1,
    S_R_IDX, S_R_SP, S_R_LT,
    S_M_ADDR, S_M_SP, S_M_LT,
    S_EQ_SP, S_DATA,
    S_R_DONE, S_M_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               branch_m_q, branch_m_d;
  logic [TIME_W-1:0]  tsh_q, tsh_d;
  logic [HW-1:0]      pcsh_q, pcsh_d;
  logic [GRF_W-1:0]   grfsh_q, grfsh_d;
  logic [HW-1:0]      addrsh_q, addrsh_d;
  logic [HW-1:0]      datash_q, datash_d;

  logic [TIME_W-1:0]  time_q;
  logic [HW-1:0]      pc_q, addr_q, data_q;
  logic [GRF_W-1:0]   grf_q;
  logic [ERR_W-1:0]   err_q;
  logic               sem_q;

  logic               is_dec, is_hex;
  logic [3:0]         nib;
  logic               abandon, restart, accept, sem_line;

  // Classify the incoming character; only lowercase hex counts as hex.
  always_comb begin
    is_dec = (char >= 8'h30) && (char <= 8'h39);
    is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66));
    nib    = is_dec ? char[3:0] : (char[3:0] + 4'd9);
  end

  // Semantic check on the shadow fields of the line about to complete.
  always_comb begin
    if (branch_m_q)
      sem_line = (pcsh_q[1:0] != 2'b00) || (addrsh_q[1:0] != 2'b00);
    else
      sem_line = (pcsh_q[1:0] != 2'b00) || (grfsh_q > GRF_W'(31));
  end

  // Next-state, digit counting and shadow-field accumulation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    branch_m_d = branch_m_q;
    tsh_d      = tsh_q;
    pcsh_d     = pcsh_q;
    grfsh_d    = grfsh_q;
    addrsh_d   = addrsh_q;
    datash_d   = datash_q;
    abandon    = 1'b0;
    restart    = 1'b0;
    accept     = 1'b0;

    // A caret mid-line resyncs; in IDLE and the DONE states it simply starts a line.
    if (char == CH_CARET && state_q != S_IDLE && state_q != S_R_DONE && state_q != S_M_DONE) begin
      abandon = 1'b1;
      restart = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (char == CH_CARET) restart = 1'b1;
        end
        S_TIME: begin
          if (is_dec && cnt_q < CW'(TIME_DIGITS)) begin
            tsh_d = TIME_W'(tsh_q * TIME_W'(10)) + TIME_W'(nib);
            cnt_d = cnt_q + CW'(1);
          end else if (char == CH_AT && cnt_q != '0) begin
            state_d = S_PC;
            cnt_d   = '0;
          end else abandon = 1'b1;
        end
        S_PC: begin
          if (is_hex && cnt_q < CW'(HEX_DIGITS)) begin
            pcsh_d = (pcsh_q << 4) | HW'(nib);
            cnt_d  = cnt_q + CW'(1);
          end else if (char == CH_COLON && cnt_q == CW'(HEX_DIGITS)) begin
            state_d = S_SP1;
            cnt_d   = '0;
          end else abandon = 1'b1;
        end
        S_SP1: begin
          if (char == CH_SPACE) begin
            state_d = S_SP1;
          end else if (char == CH_DOLL) begin
            state_d    = S_R_IDX;
            branch_m_d = 1'b0;
            cnt_d      = '0;
          end else if (char == CH_STAR) begin
            state_d    = S_M_ADDR;
            branch_m_d = 1'b1;
            cnt_d      = '0;
          end else abandon = 1'b1;
        end
        S_R_IDX: begin
          if (is_dec && cnt_q < CW'(GRF_DIGITS)) begin
            grfsh_d = GRF_W'(grfsh_q * GRF_W'(10)) + GRF_W'(nib);
            cnt_d   = cnt_q + CW'(1);
          end else if (char == CH_SPACE && cnt_q != '0) begin
            state_d = S_R_SP;
          end else if (char == CH_LT && cnt_q != '0) begin
            state_d = S_R_LT;
          end else abandon = 1'b1;
        end
        S_R_SP: begin
          if (char == CH_SPACE) state_d = S_R_SP;
          else if (char == CH_LT) state_d = S_R_LT;
          else abandon = 1'b1;
        end
        S_M_ADDR: begin
          if (is_hex && cnt_q < CW'(HEX_DIGITS)) begin
            addrsh_d = (addrsh_q << 4) | HW'(nib);
            cnt_d    = cnt_q + CW'(1);
          end else if (char == CH_SPACE && cnt_q == CW'(HEX_DIGITS)) begin
            state_d = S_M_SP;
          end else if (char == CH_LT && cnt_q == CW'(HEX_DIGITS)) begin
            state_d = S_M_LT;
          end else abandon = 1'b1;
        end
        S_M_SP: begin
          if (char == CH_SPACE) state_d = S_M_SP;
          else if (char == CH_LT) state_d = S_M_LT;
          else abandon = 1'b1;
        end
        S_R_LT, S_M_LT: begin
          if (char == CH_EQ) begin
            state_d = S_EQ_SP;
            cnt_d   = '0;
          end else abandon = 1'b1;
        end
        S_EQ_SP: begin
          if (char == CH_SPACE) begin
            state_d = S_EQ_SP;
          end else if (is_hex) begin
            state_d  = S_DATA;
            datash_d = HW'(nib);
            cnt_d    = CW'(1);
          end else abandon = 1'b1;
        end
        S_DATA: begin
          if (is_hex && cnt_q < CW'(HEX_DIGITS)) begin
            datash_d = (datash_q << 4) | HW'(nib);
            cnt_d    = cnt_q + CW'(1);
          end else if (char == CH_HASH && cnt_q == CW'(HEX_DIGITS)) begin
            accept  = 1'b1;
            state_d = branch_m_q ? S_M_DONE : S_R_DONE;
          end else abandon = 1'b1;
        end
        S_R_DONE, S_M_DONE: begin
          if (char == CH_CARET) restart = 1'b1;
          else state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (restart) begin
      state_d    = S_TIME;
      cnt_d      = '0;
      branch_m_d = 1'b0;
      tsh_d      = '0;
      pcsh_d     = '0;
      grfsh_d    = '0;
      addrsh_d   = '0;
      datash_d   = '0;
    end else if (abandon) begin
      state_d = S_IDLE;
    end
  end

  // Parser state, digit counter and shadow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      branch_m_q <= 1'b0;
      tsh_q      <= '0;
      pcsh_q     <= '0;
      grfsh_q    <= '0;
      addrsh_q   <= '0;
      datash_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      branch_m_q <= branch_m_d;
      tsh_q      <= tsh_d;
      pcsh_q     <= pcsh_d;
      grfsh_q    <= grfsh_d;
      addrsh_q   <= addrsh_d;
      datash_q   <= datash_d;
    end
  end

  // Latch reported fields on completion and keep the saturating error count.
  always_ff @(posedge clk) begin
    if (reset) begin
      time_q <= '0;
      pc_q   <= '0;
      grf_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      sem_q  <= 1'b0;
      err_q  <= '0;
    end else begin
      sem_q <= accept && sem_line;
      if (accept) begin
        time_q <= tsh_q;
        pc_q   <= pcsh_q;
        data_q <= datash_q;
        if (branch_m_q) addr_q <= addrsh_q;
        else            grf_q  <= grfsh_q;
      end
      // Abandonment and a semantic error never coincide, but either alone bumps by one.
      if ((abandon || (accept && sem_line)) && err_q != '1)
        err_q <= err_q + ERR_W'(1);
    end
  end

  assign format_type = (state_q == S_R_DONE) ? 2'b01 :
                       (state_q == S_M_DONE) ? 2'b10 : 2'b00;
  assign line_valid  = (format_type != 2'b00);
  assign sem_err     = sem_q;
  assign time_val    = time_q;
  assign pc_val      = pc_q;
  assign grf_idx     = grf_q;
  assign addr_val    = addr_q;
  assign data_val    = data_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_cpu_trace_parser.sv
// Testbench for cpu_trace_parser: expected line reports are queued as lines
// are sent and popped by a monitor whenever the DUT reports a line.
module tb_cpu_trace_parser;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic [7:0]  ch;

  logic [1:0]  format_type, format_type2;
  logic        line_valid, line_valid2, sem_err, sem_err2;
  logic [15:0] time_val, time_val2;
  logic [31:0] pc_val, pc_val2, addr_val, addr_val2, data_val, data_val2;
  logic [13:0] grf_idx, grf_idx2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  ft;
    logic        sem;
    logic [15:0] t;
    logic [31:0] pc;
    logic [13:0] grf;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;

  logic [15:0] m_time;
  logic [31:0] m_pc, m_addr, m_data;
  logic [13:0] m_grf;
  int          exp_err  = 0;
  int          exp_err2 = 0;

  cpu_trace_parser dut (
    .clk(clk), .reset(reset), .char(ch),
    .format_type(format_type), .line_valid(line_valid), .sem_err(sem_err),
    .time_val(time_val), .pc_val(pc_val), .grf_idx(grf_idx),
    .addr_val(addr_val), .data_val(data_val), .err_cnt(err_cnt)
  );

  cpu_trace_parser #(.ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset2), .char(ch),
    .format_type(format_type2), .line_valid(line_valid2), .sem_err(sem_err2),
    .time_val(time_val2), .pc_val(pc_val2), .grf_idx(grf_idx2),
    .addr_val(addr_val2), .data_val(data_val2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  function automatic void note_err();
    if (exp_err < 255) exp_err++;
    exp_err2++;
  endfunction

  function automatic void expect_line(input bit is_m, input int t, input logic [31:0] pc,
                                      input int g, input logic [31:0] addr, input logic [31:0] data);
    exp_t x;
    logic s;
    m_time = t[15:0];
    m_pc   = pc;
    m_data = data;
    if (is_m) m_addr = addr;
    else      m_grf  = g[13:0];
    s = (pc[1:0] != 2'b00) || (is_m ? (addr[1:0] != 2'b00) : (g > 31));
    x = '{ft: (is_m ? 2'b10 : 2'b01), sem: s, t: m_time, pc: m_pc, grf: m_grf, addr: m_addr, data: m_data};
    q.push_back(x);
    if (s) note_err();
  endfunction

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      ch = s[i];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ch = 8'h0A;
    end
  endtask

  // Monitor: every reported line must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (format_type != 2'b00 || line_valid || sem_err) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got format_type=%b line_valid=%b sem_err=%b, want no report",
                 format_type, line_valid, sem_err);
      end else begin
        e = q.pop_front();
        if (format_type !== e.ft || line_valid !== 1'b1 || sem_err !== e.sem ||
            time_val !== e.t || pc_val !== e.pc || grf_idx !== e.grf ||
            addr_val !== e.addr || data_val !== e.data) begin
          bad++;
          $display("FAIL line_report: got ft=%b v=%b sem=%b t=%0d pc=%h grf=%0d addr=%h data=%h, want ft=%b v=1 sem=%b t=%0d pc=%h grf=%0d addr=%h data=%h",
                   format_type, line_valid, sem_err, time_val, pc_val, grf_idx, addr_val, data_val,
                   e.ft, e.sem, e.t, e.pc, e.grf, e.addr, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    total++;
    if ({format_type, line_valid, sem_err} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got ft=%b v=%b sem=%b, want 0", format_type, line_valid, sem_err);
    end
    total++;
    if ({time_val, pc_val, grf_idx, addr_val, data_val} !== '0) begin
      bad++;
      $display("FAIL reset_fields: got t=%0d pc=%h grf=%0d addr=%h data=%h, want all 0",
               time_val, pc_val, grf_idx, addr_val, data_val);
    end
    total++;
    if (err_cnt !== 8'd0 || err_cnt2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_err: got %0d/%0d, want 0/0", err_cnt, err_cnt2);
    end
  endtask

  task automatic test_reg_line();
    expect_line(0, 12, 32'h3000, 5, 32'h0, 32'h0000abcd);
    send("^12@00003000: $5 <= 0000abcd#");
    idle(3);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL reg_line_pulse: got %0d pending, want 0", q.size());
      q.delete();
    end
    total++;
    if (err_cnt !== exp_err[7:0]) begin
      bad++;
      $display("FAIL reg_line_err: got %0d, want %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_mem_line();
    expect_line(1, 7, 32'h3004, 0, 32'h1c, 32'hdeadbeef);
    send("^7@00003004: *0000001c<=deadbeef#");
    idle(3);
    total++;
    if (q.size() != 0 || grf_idx !== 14'd5) begin
      bad++;
      $display("FAIL mem_line: got pending=%0d grf=%0d, want 0 and 5", q.size(), grf_idx);
      q.delete();
    end
  endtask

  task automatic test_sem_err();
    expect_line(0, 1, 32'h3002, 40, 32'h0, 32'h0);
    send("^1@00003002: $40 <= 00000000#");
    idle(3);
    total++;
    if (q.size() != 0 || err_cnt !== exp_err[7:0] || err_cnt2 !== 2'd1) begin
      bad++;
      $display("FAIL sem_err: got pending=%0d err=%0d err2=%0d, want 0, %0d, 1",
               q.size(), err_cnt, err_cnt2, exp_err);
      q.delete();
    end
  endtask

  task automatic test_malformed();
    send("^12345@00003000: $1 <= 00000000#");
    note_err();
    idle(2);
    total++;
    if (err_cnt !== exp_err[7:0]) begin
      bad++;
      $display("FAIL time_too_long: got err=%0d, want %0d", err_cnt, exp_err);
    end
    // mid-pc resync, then the restarted line is accepted
    note_err();
    expect_line(0, 4, 32'h3008, 2, 32'h0, 32'h1);
    send("^3@0000^4@00003008: $2 <= 00000001#");
    idle(3);
    total++;
    if (q.size() != 0 || err_cnt !== exp_err[7:0]) begin
      bad++;
      $display("FAIL resync: got pending=%0d err=%0d, want 0, %0d", q.size(), err_cnt, exp_err);
      q.delete();
    end
    // boundary counts: 4 time digits, grf 31, '<' directly after index
    expect_line(0, 9999, 32'h300c, 31, 32'h0, 32'h0000ffff);
    send("^9999@0000300c: $31<=0000ffff#");
    idle(2);
    send("^@00003000: $1 <= 00000000#");           note_err(); idle(2);
    send("^1@00003000: $12345 <= 00000000#");      note_err(); idle(2);
    send("^1@00003000: *00000010 <= 1234567#");    note_err(); idle(2);
    send("^1@00003000: *000000100 <= 12345678#");  note_err(); idle(2);
    send("^1@00003000: *00000010x <= 12345678#");  note_err(); idle(2);
    total++;
    if (q.size() != 0 || err_cnt !== exp_err[7:0]) begin
      bad++;
      $display("FAIL digit_bounds: got pending=%0d err=%0d, want 0, %0d", q.size(), err_cnt, exp_err);
      q.delete();
    end
  endtask

  task automatic test_back_to_back();
    expect_line(0, 21, 32'h4000, 7, 32'h0, 32'h11112222);
    expect_line(1, 22, 32'h4004, 0, 32'h80, 32'h33334444);
    send("^21@00004000: $7 <= 11112222#^22@00004004: *00000080 <= 33334444#");
    idle(3);
    total++;
    if (q.size() != 0 || err_cnt !== exp_err[7:0]) begin
      bad++;
      $display("FAIL back_to_back: got pending=%0d err=%0d, want 0, %0d", q.size(), err_cnt, exp_err);
      q.delete();
    end
  endtask

  task automatic test_uppercase();
    send("^1@0000300A: $1 <= 00000000#");
    note_err();
    idle(3);
    total++;
    if (err_cnt !== exp_err[7:0] || format_type !== 2'b00) begin
      bad++;
      $display("FAIL uppercase: got err=%0d ft=%b, want %0d, 00", err_cnt, format_type, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    send("^5@00003000: $3 <= 1234");
    @(negedge clk);
    reset = 1'b1;
    ch    = "5";
    @(negedge clk);
    reset = 1'b0;
    exp_err = 0;
    m_time = '0; m_pc = '0; m_grf = '0; m_addr = '0; m_data = '0;
    send("678#");
    idle(3);
    total++;
    if ({format_type, line_valid, sem_err, time_val, pc_val, grf_idx, addr_val, data_val, err_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got ft=%b t=%0d pc=%h grf=%0d addr=%h data=%h err=%0d, want all 0",
               format_type, time_val, pc_val, grf_idx, addr_val, data_val, err_cnt);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_queue: got %0d pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      send("^x");
      note_err();
      idle(1);
    end
    idle(2);
    total++;
    if (err_cnt !== exp_err[7:0]) begin
      bad++;
      $display("FAIL count_after_reset: got %0d, want %0d", err_cnt, exp_err);
    end
    total++;
    if (err_cnt2 !== ((exp_err2 > 3) ? 2'd3 : exp_err2[1:0])) begin
      bad++;
      $display("FAIL saturation: got %0d, want %0d", err_cnt2, (exp_err2 > 3) ? 3 : exp_err2);
    end
    // a good line after saturation leaves the count pinned and still reports
    expect_line(0, 3, 32'h5000, 1, 32'h0, 32'h00000042);
    send("^3@00005000: $1 <= 00000042#");
    idle(3);
    total++;
    if (q.size() != 0 || err_cnt2 !== 2'd3) begin
      bad++;
      $display("FAIL after_saturation: got pending=%0d err2=%0d, want 0, 3", q.size(), err_cnt2);
      q.delete();
    end
  endtask

  initial begin
    m_time = '0; m_pc = '0; m_grf = '0; m_addr = '0; m_data = '0;
    ch     = 8'h0A;
    reset  = 1'b1;
    reset2 = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    reset2 = 1'b0;
    test_reset();
    test_reg_line();
    test_mem_line();
    test_sem_err();
    test_malformed();
    test_back_to_back();
    test_uppercase();
    test_reset_mid();
    test_saturation();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
